// File: rtl/operand_regfile_pkg.sv
// Shared processor package: register file defaults and address types.
// Imported by operand_regfile and regfile_scoreboard.
package operand_regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the operand register file.
// Write-back clears, reservation sets; reservation wins on collision.
module regfile_scoreboard
  import operand_regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rsa_i,
  input  logic [ADDR_W-1:0] rta_i,
  output logic              busy_rs_o,
  output logic              busy_rt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_clr;
  logic [DEPTH-1:0] busy_d;

  // Apply write-back clear first, then the new producer's set.
  always_comb begin
    busy_clr = busy_q;
    if (clr_i && (clr_addr_i != ZA)) begin
      busy_clr[clr_addr_i] = 1'b0;
    end
    busy_d = busy_clr;
    if (set_i && (set_addr_i != ZA)) begin
      busy_d[set_addr_i] = 1'b1;
    end
  end

  // Readers see the post-clear, pre-set view.
  assign busy_rs_o = busy_clr[rsa_i];
  assign busy_rt_o = busy_clr[rta_i];

  // Busy vector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/operand_regfile.sv
// Operand register file: two registered read ports, one write-back port.
// Optional write-to-read forwarding under OPERAND_REGFILE_BYPASS_EN.
module operand_regfile
  import operand_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RSA,
  input  logic [ADDR_W-1:0] RTA,
  output logic [DATA_W-1:0] Rs,
  output logic [DATA_W-1:0] Rt,
  output logic              RVALID,
  output logic              BUSY_RS,
  output logic              BUSY_RT,
  input  logic              RSV,
  input  logic [ADDR_W-1:0] RDA,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic              rvalid_q;
  logic              brs_q, brt_q;
  logic              brs_w, brt_w;
  logic              we_ok;

  assign we_ok = WE && (WA != ZA);

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .set_i      (RSV),
    .set_addr_i (RDA),
    .clr_i      (WE),
    .clr_addr_i (WA),
    .rsa_i      (RSA),
    .rta_i      (RTA),
    .busy_rs_o  (brs_w),
    .busy_rt_o  (brt_w)
  );

  // Read mux; register 0 is hardwired to zero.
  always_comb begin
    rs_d = (RSA == ZA) ? '0 : regs_q[RSA];
    rt_d = (RTA == ZA) ? '0 : regs_q[RTA];
`ifdef OPERAND_REGFILE_BYPASS_EN
    if (we_ok && (WA == RSA)) begin
      rs_d = WD;
    end
    if (we_ok && (WA == RTA)) begin
      rt_d = WD;
    end
`endif
  end

  // Register storage with write-back port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_ok) begin
      regs_q[WA] <= WD;
    end
  end

  // Registered operands and flags; held while RE is low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rs_q     <= '0;
      rt_q     <= '0;
      brs_q    <= 1'b0;
      brt_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= RE;
      if (RE) begin
        rs_q  <= rs_d;
        rt_q  <= rt_d;
        brs_q <= brs_w;
        brt_q <= brt_w;
      end
    end
  end

  assign Rs      = rs_q;
  assign Rt      = rt_q;
  assign RVALID  = rvalid_q;
  assign BUSY_RS = brs_q;
  assign BUSY_RT = brt_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed self-checking bench for operand_regfile.
// Expected values follow OPERAND_REGFILE_BYPASS_EN when defined.
module tb_operand_regfile;

  logic        CLK;
  logic        RST_N;
  logic        RE;
  logic [3:0]  RSA, RTA;
  logic [15:0] Rs, Rt;
  logic        RVALID, BUSY_RS, BUSY_RT;
  logic        RSV;
  logic [3:0]  RDA;
  logic        WE;
  logic [3:0]  WA;
  logic [15:0] WD;

  int pass_cnt = 0;
  int total = 0;

  operand_regfile dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .RE      (RE),
    .RSA     (RSA),
    .RTA     (RTA),
    .Rs      (Rs),
    .Rt      (Rt),
    .RVALID  (RVALID),
    .BUSY_RS (BUSY_RS),
    .BUSY_RT (BUSY_RT),
    .RSV     (RSV),
    .RDA     (RDA),
    .WE      (WE),
    .WA      (WA),
    .WD      (WD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RE = 0; RSV = 0; WE = 0;
    RSA = 0; RTA = 0; RDA = 0; WA = 0; WD = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [15:0] exp_fwd;
  logic [15:0] exp_fwd2;

  initial begin
`ifdef OPERAND_REGFILE_BYPASS_EN
    exp_fwd  = 16'h5A5A;
    exp_fwd2 = 16'h0BEE;
`else
    exp_fwd  = 16'h0001;
    exp_fwd2 = 16'h0000;
`endif
    idle();
    RST_N = 1;
    #1 RST_N = 0;
    #2;
    check("rst_rs", Rs, 16'h0);
    check("rst_rt", Rt, 16'h0);
    check("rst_rvalid", {15'b0, RVALID}, 16'h0);
    check("rst_busy", {14'b0, BUSY_RS, BUSY_RT}, 16'h0);
    tick();
    tick();
    RST_N = 1;

    // First read after reset
    RE = 1; RSA = 3; RTA = 5;
    tick();
    idle();
    check("rd0_rs", Rs, 16'h0);
    check("rd0_rt", Rt, 16'h0);
    check("rd0_rvalid", {15'b0, RVALID}, 16'h1);
    check("rd0_busy", {14'b0, BUSY_RS, BUSY_RT}, 16'h0);

    // Write then read reg 3
    WE = 1; WA = 3; WD = 16'h00F0;
    tick();
    idle();
    check("idle_rvalid", {15'b0, RVALID}, 16'h0);
    RE = 1; RSA = 3;
    tick();
    idle();
    check("wr3_rs", Rs, 16'h00F0);
    tick();
    check("hold_rs", Rs, 16'h00F0);
    check("hold_rvalid", {15'b0, RVALID}, 16'h0);

    // Writes to register 0 are dropped
    WE = 1; WA = 0; WD = 16'hFFFF;
    tick();
    idle();
    RE = 1; RSA = 0; RTA = 0;
    tick();
    idle();
    check("r0_rs", Rs, 16'h0);
    check("r0_rt", Rt, 16'h0);

    // Reserve 7, observe busy, write back, busy cleared
    RSV = 1; RDA = 7;
    tick();
    idle();
    RE = 1; RSA = 7; RTA = 3;
    tick();
    idle();
    check("rsv7_busy_rs", {15'b0, BUSY_RS}, 16'h1);
    check("rsv7_busy_rt", {15'b0, BUSY_RT}, 16'h0);
    WE = 1; WA = 7; WD = 16'h1234;
    tick();
    idle();
    RE = 1; RSA = 7;
    tick();
    idle();
    check("wb7_rs", Rs, 16'h1234);
    check("wb7_busy", {15'b0, BUSY_RS}, 16'h0);

    // Reserve and write-back collide on 9: reservation wins
    RSV = 1; RDA = 9; WE = 1; WA = 9; WD = 16'hAAAA;
    tick();
    idle();
    RE = 1; RSA = 9; RTA = 9;
    tick();
    idle();
    check("col9_rs", Rs, 16'hAAAA);
    check("col9_rt", Rt, 16'hAAAA);
    check("col9_busy", {14'b0, BUSY_RS, BUSY_RT}, 16'h3);

    // Double reservation stays busy; still busy after re-reserve
    RSV = 1; RDA = 9;
    tick();
    idle();
    RE = 1; RSA = 9;
    tick();
    idle();
    check("rsv9_again", {15'b0, BUSY_RS}, 16'h1);

    // Same-cycle read and write of reg 4
    WE = 1; WA = 4; WD = 16'h0001;
    tick();
    idle();
    RE = 1; RSA = 4; RTA = 4;
    WE = 1; WA = 4; WD = 16'h5A5A;
    tick();
    idle();
    check("fwd4_rs", Rs, exp_fwd);
    check("fwd4_rt", Rt, exp_fwd);
    RE = 1; RSA = 4; RTA = 4;
    tick();
    idle();
    check("after4_rs", Rs, 16'h5A5A);

    // Reservation of register 0 is ignored
    RSV = 1; RDA = 0;
    tick();
    idle();
    RE = 1; RSA = 0; RTA = 0;
    tick();
    idle();
    check("rsv0_busy", {14'b0, BUSY_RS, BUSY_RT}, 16'h0);

    // Busy sampled after same-cycle clear, before same-cycle set
    RSV = 1; RDA = 11;
    tick();
    idle();
    RE = 1; RSA = 11; RTA = 12;
    WE = 1; WA = 11; WD = 16'h0BEE;
    RSV = 1; RDA = 12;
    tick();
    idle();
    check("clr11_busy_rs", {15'b0, BUSY_RS}, 16'h0);
    check("set12_busy_rt", {15'b0, BUSY_RT}, 16'h0);
    check("clr11_rs", Rs, exp_fwd2);
    RE = 1; RTA = 12;
    tick();
    idle();
    check("set12_seen", {15'b0, BUSY_RT}, 16'h1);

    // Reset mid-operation with a reservation outstanding
    RSV = 1; RDA = 2;
    tick();
    idle();
    RE = 1; RSA = 7; RTA = 9;
    tick();
    check("pre_rst_rs", Rs, 16'h1234);
    RSV = 0; RE = 0;
    WE = 1; WA = 2; WD = 16'hDEAD;
    #2 RST_N = 0;
    #1;
    check("midrst_rs", Rs, 16'h0);
    check("midrst_rt", Rt, 16'h0);
    check("midrst_flags",
          {13'b0, RVALID, BUSY_RS, BUSY_RT}, 16'h0);
    tick();
    idle();
    RST_N = 1;
    RE = 1; RSA = 2; RTA = 7;
    tick();
    idle();
    check("post_rst_busy", {14'b0, BUSY_RS, BUSY_RT}, 16'h0);
    check("post_rst_rs", Rs, 16'h0);
    check("post_rst_rt", Rt, 16'h0);
    check("post_rst_rvalid", {15'b0, RVALID}, 16'h1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
